// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the single-write-port integer register file:
// arbitrates ALU vs LSU write-back and scoreboards registers with loads in flight.
module regfile_wb_sched #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rs1,
    input  logic [4:0]  i_issue_rs2,
    input  logic [4:0]  i_issue_rd,
    input  logic        i_issue_is_load,
    output logic        o_issue_stall,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    output logic        o_alu_ready,
    input  logic        i_lsu_valid,
    input  logic [4:0]  i_lsu_rd,
    input  logic [31:0] i_lsu_data,
    output logic        o_lsu_ready,
    output logic        o_rd_wren,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic [31:0] o_busy_vec
);

    logic [31:0]      busy_reg;
    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             alu_req;
    logic             lsu_req;
    logic             alu_grant;
    logic             lsu_grant;
    logic             starved;
    logic             load_set;

    // rd==0 requests never reach the port, so they are not requests for arbitration
    assign alu_req   = i_alu_valid & (i_alu_rd != 5'd0);
    assign lsu_req   = i_lsu_valid & (i_lsu_rd != 5'd0);
    assign starved   = (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));
    assign alu_grant = alu_req & (~lsu_req | starved);
    assign lsu_grant = lsu_req & ~alu_grant;

    assign o_alu_ready = alu_grant | (i_alu_valid & (i_alu_rd == 5'd0));
    assign o_lsu_ready = lsu_grant | (i_lsu_valid & (i_lsu_rd == 5'd0));

    assign o_issue_stall = i_issue_valid &
                           (busy_reg[i_issue_rs1] | busy_reg[i_issue_rs2] | busy_reg[i_issue_rd]);
    assign load_set      = i_issue_valid & ~o_issue_stall & i_issue_is_load & (i_issue_rd != 5'd0);
    assign o_busy_vec    = busy_reg;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (alu_grant) begin
            starve_cnt_next = '0;
        end else if (alu_req && (starve_cnt_reg != {CNT_W{1'b1}})) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // x0 is hard-wired never busy
    assign busy_reg[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    busy_reg[gi] <= 1'b0;
                end else if (load_set && (i_issue_rd == 5'(gi))) begin
                    busy_reg[gi] <= 1'b1;
                end else if (lsu_grant && (i_lsu_rd == 5'(gi))) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_wren <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else if (alu_grant) begin
            o_rd_wren <= 1'b1;
            o_rd_addr <= i_alu_rd;
            o_rd_data <= i_alu_data;
        end else if (lsu_grant) begin
            o_rd_wren <= 1'b1;
            o_rd_addr <= i_lsu_rd;
            o_rd_data <= i_lsu_data;
        end else begin
            o_rd_wren <= 1'b0;
        end
    end

    // A load return must target a register that actually has a load outstanding
    a_lsu_to_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        lsu_grant |-> busy_reg[i_lsu_rd]);

endmodule
